// File: rtl/m_unit_iter.sv
// rtl/m_unit_iter.sv - iterative multiply/divide unit for the RV32M/RV64M op set
module m_unit_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      dest,
  input  logic            flush,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      dest_out,
  output logic            wr
);

  localparam int MUL_CYC = XLEN / MUL_STEP;
  localparam int CW      = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [4:0]          dest_q;
  logic                s1_q, s2_q;
  logic [CW-1:0]       cnt_q;
  logic [2*XLEN-1:0]   acc_q, mcand_q;
  logic [XLEN-1:0]     mplier_q, rem_q, quo_q, divisor_q;

  logic                accept, is_div, div_zero, div_ovf, fast, s1, s2;
  logic [XLEN-1:0]     mag1, mag2, fast_res;
  logic [2*XLEN-1:0]   partial, mul_sum, mul_fix;
  logic [XLEN-1:0]     mul_res;
  logic [XLEN:0]       div_sh, div_diff;
  logic                div_take;
  logic [XLEN-1:0]     rem_nxt, quo_nxt, quo_fix, rem_fix, div_res;

  assign accept   = start && !flush && (state_q == ST_IDLE || state_q == ST_DONE);
  assign is_div   = func3[2];
  assign div_zero = (op2 == '0);
  assign div_ovf  = is_div && !func3[0] && (op1 == MOST_NEG) && (op2 == '1);
  assign fast     = is_div && (div_zero || div_ovf);
  assign fast_res = div_zero ? (func3[1] ? op1 : '1) : (func3[1] ? '0 : op1);

  // Operand signedness: MULH both, MULHSU op1 only, DIV/REM both.
  assign s1   = op1[XLEN-1] && (is_div ? !func3[0] : (func3[1] ^ func3[0]));
  assign s2   = op2[XLEN-1] && (is_div ? !func3[0] : (func3[1:0] == 2'b01));
  assign mag1 = s1 ? -op1 : op1;
  assign mag2 = s2 ? -op2 : op2;

  assign partial = mcand_q * {{(2*XLEN-MUL_STEP){1'b0}}, mplier_q[MUL_STEP-1:0]};
  assign mul_sum = acc_q + partial;
  assign mul_fix = (s1_q ^ s2_q) ? -mul_sum : mul_sum;
  assign mul_res = (op_q == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];

  // Restoring step: shift next dividend bit into the partial remainder and trial-subtract.
  assign div_sh   = {rem_q, quo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, divisor_q};
  assign div_take = !div_diff[XLEN];
  assign rem_nxt  = div_take ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
  assign quo_nxt  = {quo_q[XLEN-2:0], div_take};
  assign quo_fix  = (s1_q ^ s2_q) ? -quo_nxt : quo_nxt;
  assign rem_fix  = s1_q ? -rem_nxt : rem_nxt;
  assign div_res  = op_q[1] ? rem_fix : quo_fix;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = fast ? ST_DONE : (is_div ? ST_DIV : ST_MUL);
        else        state_d = ST_IDLE;
      end
      ST_MUL, ST_DIV: begin
        if (flush)              state_d = ST_IDLE;
        else if (cnt_q == '0)   state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      dest_q    <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result    <= '0;
      dest_out  <= '0;
    end else if (accept) begin
      op_q      <= func3[1:0];
      dest_q    <= dest;
      s1_q      <= s1;
      s2_q      <= s2;
      cnt_q     <= is_div ? CW'(XLEN - 1) : CW'(MUL_CYC - 1);
      acc_q     <= '0;
      mcand_q   <= {{XLEN{1'b0}}, mag1};
      mplier_q  <= mag2;
      rem_q     <= '0;
      quo_q     <= mag1;
      divisor_q <= mag2;
      if (fast) begin
        result   <= fast_res;
        dest_out <= dest;
      end
    end else if (state_q == ST_MUL && !flush) begin
      acc_q    <= mul_sum;
      mcand_q  <= mcand_q << MUL_STEP;
      mplier_q <= mplier_q >> MUL_STEP;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == '0) begin
        result   <= mul_res;
        dest_out <= dest_q;
      end
    end else if (state_q == ST_DIV && !flush) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == '0) begin
        result   <= div_res;
        dest_out <= dest_q;
      end
    end
  end

  assign busy  = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign ready = (state_q == ST_DONE);
  assign wr    = ready && (dest_out != 5'd0);

endmodule

// File: tb/tb_m_unit_iter.sv
// tb/tb_m_unit_iter.sv - randomized self-checking bench for m_unit_iter
module tb_m_unit_iter;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  func3;
  logic [31:0] op1, op2;
  logic [4:0]  dest;
  logic        busy, ready, wr, busy4, ready4, wr4;
  logic [31:0] result, result4;
  logic [4:0]  dest_out, dest_out4;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  m_unit_iter #(.XLEN(32), .MUL_STEP(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3), .op1(op1), .op2(op2),
    .dest(dest), .flush(flush), .busy(busy), .ready(ready), .result(result),
    .dest_out(dest_out), .wr(wr));

  m_unit_iter #(.XLEN(32), .MUL_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .func3(func3), .op1(op1), .op2(op2),
    .dest(dest), .flush(flush), .busy(busy4), .ready(ready4), .result(result4),
    .dest_out(dest_out4), .wr(wr4));

  // Reference semantics straight from the ISA definition using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int step);
    if (!f[2]) return 32 / step + 1;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one start and waits for the selected instance's ready; lat counts edges from acceptance.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                       input bit on4, output int lat, output logic [31:0] res,
                       output logic [4:0] dout, output logic w);
    @(negedge clk);
    start = 1'b1; func3 = f; op1 = a; op2 = b; dest = d;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!(on4 ? ready4 : ready)) begin
      if (lat >= 100) begin lat = -1; break; end
      @(posedge clk); #1;
      lat++;
    end
    res  = on4 ? result4 : result;
    dout = on4 ? dest_out4 : dest_out;
    w    = on4 ? wr4 : wr;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; flush = 1'b0; func3 = 3'd0; op1 = 32'd3; op2 = 32'd4; dest = 5'd2;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, ready, wr} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {busy, ready, wr}); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (dest_out !== 5'd0) begin errors++; $display("FAIL reset_dest got=%0d exp=0", dest_out); end
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  vf [7] = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd6};
    logic [31:0] va [7] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'h80000000};
    logic [31:0] vb [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF};
    logic [31:0] ve [7] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    int          vl [7] = '{33, 33, 33, 33, 33, 1, 1};
    int lat; logic [31:0] res; logic [4:0] dout; logic w;
    for (int i = 0; i < 7; i++) begin
      issue(vf[i], va[i], vb[i], 5'(i + 5), 1'b0, lat, res, dout, w);
      checks++; if (res !== ve[i]) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, ve[i]); end
      checks++; if (lat != vl[i]) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, vl[i]); end
      checks++; if (dout !== 5'(i + 5) || w !== 1'b1) begin errors++; $display("FAIL dir%0d_dest got=%0d/%b exp=%0d/1", i, dout, w, i + 5); end
    end
  endtask

  task automatic test_random();
    int lat, el; logic [31:0] res, a, b, er; logic [4:0] dout, d; logic w; logic [2:0] f;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7)); a = pick(); b = pick(); d = 5'($urandom_range(0, 31));
      er = model(f, a, b); el = model_lat(f, a, b, 1);
      issue(f, a, b, d, 1'b0, lat, res, dout, w);
      checks++; if (res !== er) begin errors++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h got=%h exp=%h", i, f, a, b, res, er); end
      checks++; if (lat != el) begin errors++; $display("FAIL rnd%0d_latency f=%0d got=%0d exp=%0d", i, f, lat, el); end
      checks++; if (dout !== d) begin errors++; $display("FAIL rnd%0d_dest got=%0d exp=%0d", i, dout, d); end
      checks++; if (w !== (d != 0)) begin errors++; $display("FAIL rnd%0d_wr got=%b exp=%b", i, w, d != 0); end
    end
  endtask

  task automatic test_flush();
    int cyc, lat; bit seen; logic [31:0] res; logic [4:0] dout; logic w;
    @(negedge clk);
    start = 1'b1; func3 = 3'd4; op1 = 32'd100; op2 = 32'd7; dest = 5'd3;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1; seen = 1'b0;
    while (cyc < 10) begin
      @(posedge clk); #1; cyc++;
      if (ready) seen = 1'b1;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got=%b exp=1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if ({busy, ready} !== 2'b00) begin errors++; $display("FAIL flush_killed got=%b exp=00", {busy, ready}); end
    checks++; if (seen) begin errors++; $display("FAIL flush_early_ready got=1 exp=0"); end
    issue(3'd0, 32'd6, 32'd7, 5'd8, 1'b0, lat, res, dout, w);
    checks++; if (res !== 32'd42 || lat != 33 || dout !== 5'd8) begin errors++; $display("FAIL flush_restart got=%h/%0d/%0d exp=2a/33/8", res, lat, dout); end
  endtask

  task automatic test_flush_done();
    int lat; logic [31:0] res; logic [4:0] dout; logic w;
    issue(3'd7, 32'd50, 32'd7, 5'd11, 1'b0, lat, res, dout, w);
    checks++; if (res !== 32'd1) begin errors++; $display("FAIL fdone_result got=%h exp=1", res); end
    flush = 1'b1; start = 1'b1; func3 = 3'd0; op1 = 32'd2; op2 = 32'd3; dest = 5'd12;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fdone_ready_kept got=%b exp=1", ready); end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if ({busy, ready} !== 2'b00) begin errors++; $display("FAIL fdone_start_rejected got=%b exp=00", {busy, ready}); end
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_flush_start got=%b exp=0", busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (result !== 32'd1 || dest_out !== 5'd11) begin errors++; $display("FAIL hold got=%h/%0d exp=1/11", result, dest_out); end
  endtask

  task automatic test_back_to_back();
    int lat, gap; logic [31:0] res, a, b, er; logic [4:0] dout; logic w;
    a = $urandom; b = $urandom;
    issue(3'd1, a, b, 5'd14, 1'b0, lat, res, dout, w);
    checks++; if (res !== model(3'd1, a, b)) begin errors++; $display("FAIL b2b_first got=%h exp=%h", res, model(3'd1, a, b)); end
    a = $urandom; b = $urandom; er = model(3'd3, a, b);
    start = 1'b1; func3 = 3'd3; op1 = a; op2 = b; dest = 5'd15;
    @(posedge clk); #1;
    start = 1'b0; gap = 1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    while (!ready && gap < 100) begin
      if (gap == 5) begin start = 1'b1; func3 = 3'd4; op1 = 32'd9; op2 = 32'd2; dest = 5'd20; end
      else start = 1'b0;
      @(posedge clk); #1; gap++;
    end
    checks++; if (gap != 33) begin errors++; $display("FAIL b2b_gap got=%0d exp=33", gap); end
    checks++; if (result !== er || dest_out !== 5'd15) begin errors++; $display("FAIL b2b_second got=%h/%0d exp=%h/15", result, dest_out, er); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width got=%b exp=0", ready); end
    issue(3'd0, 32'd3, 32'd5, 5'd0, 1'b0, lat, res, dout, w);
    checks++; if (res !== 32'd15 || w !== 1'b0) begin errors++; $display("FAIL dest0 got=%h/%b exp=f/0", res, w); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    start = 1'b1; func3 = 3'd0; op1 = 32'd7; op2 = 32'd3; dest = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got=%b exp=1", busy); end
    rst = 1'b1; flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    checks++; if ({busy, ready, wr} !== 3'b000 || result !== 32'h0 || dest_out !== 5'd0) begin
      errors++; $display("FAIL rmid_outputs got=%b/%h/%0d exp=000/0/0", {busy, ready, wr}, result, dest_out);
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL rmid_ready got=1 exp=0"); end
  endtask

  task automatic test_step4();
    int lat, el; logic [31:0] res, a, b, er; logic [4:0] dout; logic w; logic [2:0] f;
    do_reset();
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b1, lat, res, dout, w);
    checks++; if (res !== 32'hFFFFFFFE || lat != 9) begin errors++; $display("FAIL step4_mulhu got=%h/%0d exp=fffffffe/9", res, lat); end
    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 3)); a = pick(); b = pick();
      er = model(f, a, b); el = model_lat(f, a, b, 4);
      issue(f, a, b, 5'd2, 1'b1, lat, res, dout, w);
      checks++; if (res !== er || lat != el) begin errors++; $display("FAIL step4_rnd%0d f=%0d got=%h/%0d exp=%h/%0d", i, f, res, lat, er, el); end
    end
    do_reset();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; op1 = '0; op2 = '0; dest = '0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_flush_done();
    test_back_to_back();
    test_reset_mid();
    test_step4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time=%0t limit=1000000", $time);
    $fatal(1);
  end

endmodule

// File: doc/m_unit_iter.md
M_UNIT_ITER -- requirements
Module: m_unit_iter

Interface
REQ-001 Parameter XLEN, default 32, operand/result width (SHALL be 32 or 64).
REQ-002 Parameter MUL_STEP, default 1, multiplier bits retired per cycle (SHALL be 1, 2, 4 or 8 and SHALL divide XLEN).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  issue request, sampled on the clock edge.
REQ-006 func3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 op1, op2  in  XLEN each  rs1/rs2 values, already forwarded.
REQ-008 dest  in  5  destination register index.
REQ-009 flush  in  1  pipeline flush; kills any in-flight operation.
REQ-010 busy  out  1  operation iterating; new starts are ignored.
REQ-011 ready  out  1  one-cycle pulse; result and dest_out are valid.
REQ-012 result  out  XLEN  registered result.
REQ-013 dest_out  out  5  registered copy of the accepted dest.
REQ-014 wr  out  1  register-file write enable; SHALL be asserted only with ready and SHALL be 0 when dest_out==0.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, MUL, DIV, DONE; busy SHALL be 1 only in MUL or DIV; ready SHALL be 1 only in DONE.
REQ-016 A start SHALL be accepted only in IDLE or DONE with flush=0; acceptance SHALL latch op1, op2, func3 and dest.
REQ-017 A start in MUL or DIV SHALL be ignored, with no side effect.
REQ-018 Accepted MUL* SHALL enter MUL for XLEN/MUL_STEP cycles, then DONE; ready SHALL rise XLEN/MUL_STEP+1 cycles after the accepting edge (33 for defaults).
REQ-019 Accepted DIV* SHALL enter DIV for XLEN cycles, one restoring step per cycle, then DONE; ready SHALL rise XLEN+1 cycles after acceptance.
REQ-020 Divide by zero SHALL bypass DIV and go directly to DONE, giving ready 1 cycle after acceptance; results: DIV/DIVU all-ones, REM/REMU op1.
REQ-021 Signed overflow (op1 = most-negative, op2 = -1, DIV/REM) SHALL take the same 1-cycle path; results: DIV most-negative, REM 0.
REQ-022 MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN] with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-023 DIV SHALL round toward zero; REM SHALL carry the sign of the dividend; signed ops SHALL use magnitudes and apply the sign fix in the final cycle without adding latency.
REQ-024 DONE SHALL last exactly one cycle, then go to IDLE, or to MUL/DIV/DONE if a start is accepted in that same cycle (back-to-back issue).
REQ-025 flush in MUL or DIV SHALL force IDLE at the next edge; no ready SHALL be produced for the killed operation.
REQ-026 flush in DONE SHALL NOT retract the current ready pulse; a start in that same cycle SHALL be rejected.
REQ-027 flush and start in the same IDLE cycle: the start SHALL be rejected.
REQ-028 result and dest_out SHALL hold their values between ready pulses.

Reset
REQ-029 With rst=1 at an edge, the block SHALL enter IDLE, and busy, ready and wr SHALL be 0, result 0 and dest_out 0, regardless of the state it was in.
REQ-030 rst SHALL take priority over start and flush; a reset during MUL or DIV SHALL discard the operation with no ready.

Verification
REQ-031 MUL op1=7, op2=-3 (0xFFFFFFFD), dest=5 -> ready at cycle 33, result 0xFFFFFFEB, wr=1, dest_out=5.
REQ-032 MULHU op1=op2=0xFFFFFFFF -> result 0xFFFFFFFE; MULHSU op1=-1, op2=0xFFFFFFFF -> result 0xFFFFFFFF; with MUL_STEP=4 ready at cycle 9.
REQ-033 DIV op1=-7, op2=2 -> result -3 (0xFFFFFFFD) at cycle 33; REM with the same operands -> -1; DIVU op1=5, op2=0 -> 0xFFFFFFFF at cycle 1; REM op1=0x80000000, op2=-1 -> 0 at cycle 1.
REQ-034 flush at cycle 10 of a DIV -> busy=0 from cycle 11, no ready; a start at cycle 11 is accepted and completes normally.
REQ-035 Back-to-back: a second start accepted in the DONE cycle of the first -> two ready pulses 33 cycles apart; a start asserted during busy is ignored; dest=0 -> ready=1 with wr=0.
REQ-036 rst asserted mid-MUL -> all outputs return to reset values at the next edge; no ready follows.
